// File: rtl/login_sequencer.sv
// Login controller: 4-digit ID capture and lookup, password-check sequencing,
// session tracking, failure counting. Define LOGIN_LOCKOUT_EN to build the lockout state.
`timescale 1ns/1ps
module login_sequencer #(
  parameter int CHECK_TIMEOUT = 64,
  parameter int MAX_FAILS     = 3,
  parameter int LOCK_CYCLES   = 1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       EnterDigit,
  input  logic [3:0] InputSwitches,
  input  logic       Authenticated,
  input  logic       LogOutPulse,
  output logic       BeginCheck,
  output logic [4:0] InternalID,
  output logic       LoggedIn,
  output logic       LockedOut,
  output logic       BadID,
  output logic [2:0] FailCount
);

  localparam int         TW    = (CHECK_TIMEOUT > 1) ? $clog2(CHECK_TIMEOUT) : 1;
  localparam logic [4:0] NO_ID = 5'h1F;

  typedef enum logic [2:0] {
    S_ID_ENTRY,
    S_ID_LOOKUP,
    S_START_CHECK,
    S_PSWD_ENTRY,
    S_WAIT_RESULT,
    S_FAIL,
    S_SESSION
`ifdef LOGIN_LOCKOUT_EN
    , S_LOCKOUT
`endif
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_id;
  logic [1:0]      r_id_cnt;
  logic [2:0]      r_pw_cnt;
  logic [TW-1:0]   r_timer;
  logic [4:0]      r_internal_id;
  logic            r_bad_id;
  logic [2:0]      r_fail_cnt;

  logic            w_hit;
  logic [4:0]      w_map_id;
  logic [2:0]      w_fail_inc;
  logic            w_timeout;

  always_comb begin
    w_hit    = 1'b1;
    w_map_id = NO_ID;
    case (r_id)
      16'h8522: w_map_id = 5'd0;
      16'h4700: w_map_id = 5'd1;
      16'h5928: w_map_id = 5'd2;
      16'h2071: w_map_id = 5'd3;
      16'hFFFF: w_map_id = 5'd4;
      default:  w_hit    = 1'b0;
    endcase
  end

  assign w_fail_inc = (r_fail_cnt == 3'd7) ? 3'd7 : r_fail_cnt + 3'd1;
  assign w_timeout  = (r_timer == TW'(CHECK_TIMEOUT - 1));

`ifdef LOGIN_LOCKOUT_EN
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [LW-1:0] r_lock_cnt;
  logic          w_lock_trip;
  logic          w_lock_done;

  assign w_lock_trip = (w_fail_inc == 3'(MAX_FAILS));
  assign w_lock_done = (r_lock_cnt == LW'(LOCK_CYCLES - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_lock_cnt <= '0;
    end else if (r_state == S_LOCKOUT) begin
      r_lock_cnt <= w_lock_done ? '0 : r_lock_cnt + LW'(1);
    end
  end

  assign LockedOut = (r_state == S_LOCKOUT);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MAX_FAILS == LOCK_CYCLES);
  assign LockedOut    = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_ID_ENTRY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ID_ENTRY:    if (EnterDigit && r_id_cnt == 2'd3) w_next = S_ID_LOOKUP;
      S_ID_LOOKUP:   w_next = w_hit ? S_START_CHECK : S_FAIL;
      S_START_CHECK: w_next = S_PSWD_ENTRY;
      S_PSWD_ENTRY:  if (EnterDigit && r_pw_cnt == 3'd5) w_next = S_WAIT_RESULT;
      S_WAIT_RESULT: begin
        // Authenticated wins over a timeout landing in the same cycle
        if (Authenticated)  w_next = S_SESSION;
        else if (w_timeout) w_next = S_FAIL;
      end
      S_FAIL: begin
        w_next = S_ID_ENTRY;
`ifdef LOGIN_LOCKOUT_EN
        if (w_lock_trip) w_next = S_LOCKOUT;
`endif
      end
      S_SESSION:     if (LogOutPulse || !Authenticated) w_next = S_ID_ENTRY;
`ifdef LOGIN_LOCKOUT_EN
      S_LOCKOUT:     if (w_lock_done) w_next = S_ID_ENTRY;
`endif
      default:       w_next = S_ID_ENTRY;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_id          <= '0;
      r_id_cnt      <= '0;
      r_pw_cnt      <= '0;
      r_timer       <= '0;
      r_internal_id <= NO_ID;
      r_bad_id      <= 1'b0;
      r_fail_cnt    <= '0;
    end else begin
      r_bad_id <= (r_state == S_ID_LOOKUP) && !w_hit;
      case (r_state)
        S_ID_ENTRY: begin
          if (EnterDigit) begin
            r_id     <= {r_id[11:0], InputSwitches};
            r_id_cnt <= r_id_cnt + 2'd1;
          end
        end
        S_ID_LOOKUP: r_internal_id <= w_map_id;
        S_PSWD_ENTRY: begin
          if (EnterDigit) begin
            if (r_pw_cnt == 3'd5) begin
              r_pw_cnt <= '0;
              r_timer  <= '0;
            end else begin
              r_pw_cnt <= r_pw_cnt + 3'd1;
            end
          end
        end
        S_WAIT_RESULT: begin
          if (Authenticated)   r_fail_cnt <= '0;
          else if (!w_timeout) r_timer    <= r_timer + TW'(1);
        end
        S_FAIL: begin
          r_fail_cnt    <= w_fail_inc;
          r_internal_id <= NO_ID;
          r_id_cnt      <= '0;
          r_pw_cnt      <= '0;
        end
        S_SESSION: if (LogOutPulse || !Authenticated) r_internal_id <= NO_ID;
`ifdef LOGIN_LOCKOUT_EN
        S_LOCKOUT: if (w_lock_done) r_fail_cnt <= '0;
`endif
        default: ;
      endcase
    end
  end

  assign BeginCheck = (r_state == S_START_CHECK);
  assign LoggedIn   = (r_state == S_SESSION);
  assign InternalID = r_internal_id;
  assign BadID      = r_bad_id;
  assign FailCount  = r_fail_cnt;

endmodule

// File: tb/tb_login_sequencer.sv
// Randomized scenario bench for login_sequencer; expectations come from the ID table,
// the timing rules and a failure-count model kept here.
`timescale 1ns/1ps
module tb_login_sequencer;
  localparam int T  = 24;
  localparam int MF = 3;
  localparam int LC = 16;
`ifdef LOGIN_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       EnterDigit;
  logic [3:0] InputSwitches;
  logic       Authenticated;
  logic       LogOutPulse;
  logic       BeginCheck;
  logic [4:0] InternalID;
  logic       LoggedIn;
  logic       LockedOut;
  logic       BadID;
  logic [2:0] FailCount;

  int n_vec = 0;
  int n_err = 0;
  int exp_fails = 0;
  logic [15:0] ids [5] = '{16'h8522, 16'h4700, 16'h5928, 16'h2071, 16'hFFFF};

  login_sequencer #(.CHECK_TIMEOUT(T), .MAX_FAILS(MF), .LOCK_CYCLES(LC)) dut (
    .Clk(Clk), .Reset(Reset), .EnterDigit(EnterDigit), .InputSwitches(InputSwitches),
    .Authenticated(Authenticated), .LogOutPulse(LogOutPulse), .BeginCheck(BeginCheck),
    .InternalID(InternalID), .LoggedIn(LoggedIn), .LockedOut(LockedOut),
    .BadID(BadID), .FailCount(FailCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [4:0] ref_lookup(input logic [15:0] id);
    for (int k = 0; k < 5; k++) if (id == ids[k]) return 5'(k);
    return 5'h1F;
  endfunction

  function automatic logic [15:0] rand_bad_id();
    logic [15:0] v;
    do v = 16'($urandom); while (ref_lookup(v) != 5'h1F);
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      EnterDigit  = 1'b0;
      LogOutPulse = 1'($urandom);
      n_vec++;
      if (BeginCheck !== 1'b0 || LoggedIn !== 1'b0) begin
        n_err++;
        $display("FAIL idle_outputs: BeginCheck=%b LoggedIn=%b, required 0/0", BeginCheck, LoggedIn);
      end
      step();
    end
    LogOutPulse = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    InputSwitches = d;
    EnterDigit    = 1'b1;
    LogOutPulse   = 1'b0;
    step();
    EnterDigit    = 1'b0;
    InputSwitches = 4'($urandom);
  endtask

  task automatic run_lockout();
    for (int i = 1; i < LC; i++) begin
      EnterDigit    = 1'($urandom);
      InputSwitches = 4'($urandom);
      step();
      n_vec++;
      if (LockedOut !== 1'b1) begin
        n_err++;
        $display("FAIL lockout_hold: cycle %0d LockedOut=%b, required 1", i, LockedOut);
      end
    end
    EnterDigit = 1'($urandom);
    step();
    EnterDigit = 1'b0;
    exp_fails  = 0;
    n_vec++;
    if (LockedOut !== 1'b0 || FailCount !== 3'd0) begin
      n_err++;
      $display("FAIL lockout_end: LockedOut=%b FailCount=%0d, required 0/0", LockedOut, FailCount);
    end
  endtask

  // Called while the DUT is in its one FAIL cycle.
  task automatic fail_exit();
    bit lock;
    n_vec++;
    if (FailCount !== 3'(exp_fails)) begin
      n_err++;
      $display("FAIL fail_cycle_count: FailCount=%0d, required %0d", FailCount, exp_fails);
    end
    exp_fails = (exp_fails == 7) ? 7 : exp_fails + 1;
    lock      = LOCK_EN && (exp_fails == MF);
    step();
    n_vec++;
    if (FailCount !== 3'(exp_fails) || LockedOut !== lock || BadID !== 1'b0) begin
      n_err++;
      $display("FAIL fail_exit: FailCount=%0d LockedOut=%b BadID=%b, required %0d/%b/0",
               FailCount, LockedOut, BadID, exp_fails, lock);
    end
    if (lock) run_lockout();
  endtask

  task automatic enter_id(input logic [15:0] id, output logic [4:0] exp_id);
    logic [15:0] sh;
    sh = id;
    for (int k = 0; k < 4; k++) begin
      idle($urandom_range(0, 2));
      send_digit(sh[15:12]);
      sh = sh << 4;
    end
    exp_id = ref_lookup(id);
    n_vec++;
    if (BeginCheck !== 1'b0 || BadID !== 1'b0) begin
      n_err++;
      $display("FAIL lookup_cycle: BeginCheck=%b BadID=%b, required 0/0", BeginCheck, BadID);
    end
    step();
    if (exp_id != 5'h1F) begin
      n_vec++;
      if (BeginCheck !== 1'b1 || InternalID !== exp_id || BadID !== 1'b0) begin
        n_err++;
        $display("FAIL start_check: BeginCheck=%b InternalID=%h BadID=%b, required 1/%h/0",
                 BeginCheck, InternalID, BadID, exp_id);
      end
      EnterDigit    = 1'b1;
      InputSwitches = 4'($urandom);
      step();
      EnterDigit = 1'b0;
      n_vec++;
      if (BeginCheck !== 1'b0) begin
        n_err++;
        $display("FAIL begincheck_width: BeginCheck=%b, required 0", BeginCheck);
      end
    end else begin
      n_vec++;
      if (BadID !== 1'b1 || InternalID !== 5'h1F || BeginCheck !== 1'b0) begin
        n_err++;
        $display("FAIL bad_id: BadID=%b InternalID=%h BeginCheck=%b, required 1/1f/0",
                 BadID, InternalID, BeginCheck);
      end
      fail_exit();
    end
  endtask

  task automatic enter_pswd();
    for (int k = 0; k < 6; k++) begin
      idle($urandom_range(0, 2));
      send_digit(4'($urandom));
    end
  endtask

  task automatic wait_auth(input int d, input logic [4:0] exp_id);
    for (int i = 0; i < d; i++) begin
      n_vec++;
      if (LoggedIn !== 1'b0) begin
        n_err++;
        $display("FAIL wait_early_login: LoggedIn=%b, required 0", LoggedIn);
      end
      step();
    end
    Authenticated = 1'b1;
    step();
    exp_fails = 0;
    n_vec++;
    if (LoggedIn !== 1'b1 || FailCount !== 3'd0 || InternalID !== exp_id) begin
      n_err++;
      $display("FAIL login: LoggedIn=%b FailCount=%0d InternalID=%h, required 1/0/%h",
               LoggedIn, FailCount, InternalID, exp_id);
    end
  endtask

  task automatic wait_timeout();
    Authenticated = 1'b0;
    for (int i = 0; i < T; i++) begin
      n_vec++;
      if (LoggedIn !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_login: LoggedIn=%b, required 0", LoggedIn);
      end
      step();
    end
    fail_exit();
  endtask

  task automatic session(input logic [4:0] exp_id, input bit logout);
    int n;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      EnterDigit    = 1'($urandom);
      InputSwitches = 4'($urandom);
      n_vec++;
      if (LoggedIn !== 1'b1 || InternalID !== exp_id) begin
        n_err++;
        $display("FAIL session_hold: LoggedIn=%b InternalID=%h, required 1/%h", LoggedIn, InternalID, exp_id);
      end
      step();
    end
    EnterDigit = 1'b0;
    if (logout) begin
      LogOutPulse = 1'b1;
      step();
      LogOutPulse   = 1'b0;
      Authenticated = 1'b0;
      n_vec++;
      if (LoggedIn !== 1'b0 || InternalID !== 5'h1F) begin
        n_err++;
        $display("FAIL logout: LoggedIn=%b InternalID=%h, required 0/1f", LoggedIn, InternalID);
      end
    end else begin
      Authenticated = 1'b0;
      step();
      n_vec++;
      if (LoggedIn !== 1'b0) begin
        n_err++;
        $display("FAIL auth_drop: LoggedIn=%b, required 0", LoggedIn);
      end
    end
  endtask

  task automatic good_login(input logic [15:0] id, input int d, input bit logout);
    logic [4:0] eid;
    enter_id(id, eid);
    enter_pswd();
    wait_auth(d, eid);
    session(eid, logout);
  endtask

  task automatic timeout_attempt(input logic [15:0] id);
    logic [4:0] eid;
    enter_id(id, eid);
    enter_pswd();
    wait_timeout();
  endtask

  task automatic bad_attempt(input logic [15:0] id);
    logic [4:0] eid;
    enter_id(id, eid);
  endtask

  task automatic test_reset();
    Reset = 1'b0; EnterDigit = 1'b0; InputSwitches = '0; Authenticated = 1'b0; LogOutPulse = 1'b0;
    step(); step();
    n_vec++;
    if (BeginCheck !== 1'b0 || LoggedIn !== 1'b0 || LockedOut !== 1'b0 || BadID !== 1'b0 ||
        FailCount !== 3'd0 || InternalID !== 5'h1F) begin
      n_err++;
      $display("FAIL reset_values: BC=%b LI=%b LO=%b BAD=%b FC=%0d ID=%h, required 0/0/0/0/0/1f",
               BeginCheck, LoggedIn, LockedOut, BadID, FailCount, InternalID);
    end
    Reset = 1'b1;
    exp_fails = 0;
    step();
  endtask

  task automatic test_login();
    good_login(16'h8522, 20, 1'b1);
  endtask

  task automatic test_bad_id();
    bad_attempt(16'h1234);
  endtask

  task automatic test_timeout();
    timeout_attempt(16'h4700);
  endtask

  task automatic test_auth_priority();
    good_login(16'hFFFF, T - 1, 1'b0);
  endtask

  task automatic test_lockout();
    if (LOCK_EN) begin
      bad_attempt(rand_bad_id());
      timeout_attempt(16'h2071);
      bad_attempt(16'h0000);
    end else begin
      for (int i = 0; i < 8; i++) bad_attempt(rand_bad_id());
    end
    good_login(16'h5928, 3, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [4:0] eid;
    bad_attempt(16'hABCD);
    send_digit(4'h2);
    send_digit(4'h0);
    Reset = 1'b0;
    #2;
    n_vec++;
    if (FailCount !== 3'd0 || InternalID !== 5'h1F || LockedOut !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: FailCount=%0d InternalID=%h LockedOut=%b, required 0/1f/0",
               FailCount, InternalID, LockedOut);
    end
    exp_fails = 0;
    step();
    Reset = 1'b1;
    enter_id(16'h5928, eid);
    n_vec++;
    if (eid != 5'd2 || InternalID !== 5'd2) begin
      n_err++;
      $display("FAIL fresh_id_after_reset: InternalID=%h, required 02", InternalID);
    end
    enter_pswd();
    wait_auth(0, eid);
    session(eid, 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0, 1:    good_login(ids[$urandom_range(0, 4)], $urandom_range(0, T - 1), 1'($urandom));
        2:       bad_attempt(rand_bad_id());
        default: timeout_attempt(ids[$urandom_range(0, 4)]);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_login();
    test_bad_id();
    test_timeout();
    test_auth_priority();
    test_lockout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
